// File: rtl/d_cache_fm_ctrl_if.sv
// Request types and the cache/memory-facing bundle of the far-memory controller.
// The package carries the request-type encoding shared by the cache and the controller.
package d_cache_fm_pkg;
  typedef enum logic {
    FILL_REQ       = 1'b0,
    DIRTY_EVICT_OP = 1'b1
  } t_fm_reqtype;
endpackage

interface d_cache_fm_ctrl_if #(
  parameter int LINE_W     = 128,
  parameter int LINE_ADR_W = 26,
  parameter int TQ_ID_W    = 2
);
  import d_cache_fm_pkg::*;

  typedef struct packed {
    logic                  valid;
    t_fm_reqtype           reqtype;
    logic [LINE_ADR_W-1:0] address;
    logic [TQ_ID_W-1:0]    tq_id;
    logic [LINE_W-1:0]     data;
  } t_fm_req;

  typedef struct packed {
    logic               valid;
    logic [TQ_ID_W-1:0] tq_id;
    logic [LINE_W-1:0]  data;
  } t_fm_rd_rsp;

  t_fm_req               cache2fm_req_q3;
  logic                  fm_ready;
  t_fm_rd_rsp            fm2cache_rd_rsp;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [LINE_ADR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0]     mem_req_wdata;
  logic                  mem_rsp_valid;
  logic [LINE_W-1:0]     mem_rsp_rdata;

  modport slave (
    input  cache2fm_req_q3, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output fm_ready, fm2cache_rd_rsp, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  modport master (
    output cache2fm_req_q3, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  fm_ready, fm2cache_rd_rsp, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/d_cache_fm_ctrl.sv
// Far-memory request controller: in-order request FIFO toward a line-wide memory port,
// outstanding-fill tag tracking and registered fill responses back to the cache.
module d_cache_fm_ctrl
  import d_cache_fm_pkg::*;
#(
  parameter int LINE_W         = 128,
  parameter int LINE_ADR_W     = 26,
  parameter int TQ_ID_W        = 2,
  parameter int REQ_DEPTH      = 8,
  parameter int RD_OUTSTANDING = 4,
  parameter int AFULL_MARGIN   = 3
) (
  input  logic               clk,
  input  logic               rst,
  d_cache_fm_ctrl_if.slave   bus,
  output logic               err_overflow,
  output logic               err_unexp_rsp
);
  localparam int PTR_W     = $clog2(REQ_DEPTH);
  localparam int TAG_PTR_W = $clog2(RD_OUTSTANDING);
  localparam logic [PTR_W:0]     REQ_FULL  = REQ_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]     AFULL_THR = AFULL_MARGIN[PTR_W:0];
  localparam logic [TAG_PTR_W:0] TAG_FULL  = RD_OUTSTANDING[TAG_PTR_W:0];

  typedef struct packed {
    logic                  evict;
    logic [LINE_ADR_W-1:0] addr;
    logic [TQ_ID_W-1:0]    tq_id;
    logic [LINE_W-1:0]     data;
  } t_entry;

  t_entry                req_mem [REQ_DEPTH];
  logic [TQ_ID_W-1:0]    tag_mem [RD_OUTSTANDING];

  logic [PTR_W-1:0]      req_wr_ptr_reg, req_rd_ptr_reg;
  logic [PTR_W:0]        req_count_reg, req_count_next;
  logic [TAG_PTR_W-1:0]  tag_wr_ptr_reg, tag_rd_ptr_reg;
  logic [TAG_PTR_W:0]    tag_count_reg, tag_count_next;
  logic                  fm_ready_reg;
  logic                  rsp_valid_reg;
  logic [TQ_ID_W-1:0]    rsp_tq_reg;
  logic [LINE_W-1:0]     rsp_data_reg;
  logic                  err_overflow_reg, err_unexp_reg;

  t_entry new_entry, head;
  logic   req_push, req_full, req_pop, push_ok;
  logic   tag_full, tag_empty, tag_push, tag_pop;

  assign new_entry = '{evict: (bus.cache2fm_req_q3.reqtype == DIRTY_EVICT_OP),
                       addr:  bus.cache2fm_req_q3.address,
                       tq_id: bus.cache2fm_req_q3.tq_id,
                       data:  bus.cache2fm_req_q3.data};
  assign head      = req_mem[req_rd_ptr_reg];

  assign req_push  = bus.cache2fm_req_q3.valid;
  assign req_full  = (req_count_reg == REQ_FULL);
  assign tag_full  = (tag_count_reg == TAG_FULL);
  assign tag_empty = (tag_count_reg == '0);

  // A fill may only leave the FIFO when there is room to remember its tq_id.
  assign bus.mem_req_valid = (req_count_reg != '0) && (head.evict || !tag_full);
  assign bus.mem_req_we    = head.evict;
  assign bus.mem_req_addr  = head.addr;
  assign bus.mem_req_wdata = head.data;

  assign req_pop  = bus.mem_req_valid && bus.mem_req_ready;
  assign push_ok  = req_push && (!req_full || req_pop);
  assign tag_push = req_pop && !head.evict;
  assign tag_pop  = bus.mem_rsp_valid && !tag_empty;

  always_comb begin
    req_count_next = req_count_reg;
    if (push_ok && !req_pop)
      req_count_next = req_count_reg + (PTR_W+1)'(1);
    else if (!push_ok && req_pop)
      req_count_next = req_count_reg - (PTR_W+1)'(1);
  end

  always_comb begin
    tag_count_next = tag_count_reg;
    if (tag_push && !tag_pop)
      tag_count_next = tag_count_reg + (TAG_PTR_W+1)'(1);
    else if (!tag_push && tag_pop)
      tag_count_next = tag_count_reg - (TAG_PTR_W+1)'(1);
  end

  // Storage arrays carry no reset; only pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (push_ok)
      req_mem[req_wr_ptr_reg] <= new_entry;
    if (tag_push)
      tag_mem[tag_wr_ptr_reg] <= head.tq_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_wr_ptr_reg   <= '0;
      req_rd_ptr_reg   <= '0;
      req_count_reg    <= '0;
      tag_wr_ptr_reg   <= '0;
      tag_rd_ptr_reg   <= '0;
      tag_count_reg    <= '0;
      fm_ready_reg     <= 1'b1;
      rsp_valid_reg    <= 1'b0;
      rsp_tq_reg       <= '0;
      rsp_data_reg     <= '0;
      err_overflow_reg <= 1'b0;
      err_unexp_reg    <= 1'b0;
    end else begin
      if (push_ok)
        req_wr_ptr_reg <= req_wr_ptr_reg + PTR_W'(1);
      if (req_pop)
        req_rd_ptr_reg <= req_rd_ptr_reg + PTR_W'(1);
      req_count_reg <= req_count_next;
      fm_ready_reg  <= ((REQ_FULL - req_count_next) >= AFULL_THR);

      if (tag_push)
        tag_wr_ptr_reg <= tag_wr_ptr_reg + TAG_PTR_W'(1);
      if (tag_pop)
        tag_rd_ptr_reg <= tag_rd_ptr_reg + TAG_PTR_W'(1);
      tag_count_reg <= tag_count_next;

      rsp_valid_reg <= tag_pop;
      if (tag_pop) begin
        rsp_tq_reg   <= tag_mem[tag_rd_ptr_reg];
        rsp_data_reg <= bus.mem_rsp_rdata;
      end

      if (req_push && !push_ok)
        err_overflow_reg <= 1'b1;
      if (bus.mem_rsp_valid && tag_empty)
        err_unexp_reg <= 1'b1;
    end
  end

  assign bus.fm_ready        = fm_ready_reg;
  assign bus.fm2cache_rd_rsp = {rsp_valid_reg, rsp_tq_reg, rsp_data_reg};
  assign err_overflow        = err_overflow_reg;
  assign err_unexp_rsp       = err_unexp_reg;
endmodule

// File: tb/tb_d_cache_fm_ctrl.sv
// Directed bench for d_cache_fm_ctrl: fills, evict ordering, backpressure, tag limit and reset.
module tb_d_cache_fm_ctrl;
  import d_cache_fm_pkg::*;

  localparam int LINE_W     = 128;
  localparam int LINE_ADR_W = 26;
  localparam int TQ_ID_W    = 2;

  logic clk = 1'b0;
  logic rst;
  logic err_overflow, err_unexp_rsp;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   issued;
  logic [LINE_W-1:0] mem_line;
  logic [TQ_ID_W-1:0] exp_tq;

  localparam logic [LINE_W-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] DATA_D = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;

  always #5 clk = ~clk;

  d_cache_fm_ctrl_if #(.LINE_W(LINE_W), .LINE_ADR_W(LINE_ADR_W), .TQ_ID_W(TQ_ID_W)) bus ();

  d_cache_fm_ctrl #(
    .LINE_W(LINE_W), .LINE_ADR_W(LINE_ADR_W), .TQ_ID_W(TQ_ID_W),
    .REQ_DEPTH(8), .RD_OUTSTANDING(4), .AFULL_MARGIN(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .err_overflow  (err_overflow),
    .err_unexp_rsp (err_unexp_rsp)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else begin
      n_pass++;
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input t_fm_reqtype rt, input logic [LINE_ADR_W-1:0] addr,
                      input logic [TQ_ID_W-1:0] tq, input logic [LINE_W-1:0] data);
    bus.cache2fm_req_q3.valid   = 1'b1;
    bus.cache2fm_req_q3.reqtype = rt;
    bus.cache2fm_req_q3.address = addr;
    bus.cache2fm_req_q3.tq_id   = tq;
    bus.cache2fm_req_q3.data    = data;
    tick();
    bus.cache2fm_req_q3.valid   = 1'b0;
  endtask

  task automatic pulse_reset();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.cache2fm_req_q3 = '0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_rsp_valid   = 1'b0;
    bus.mem_rsp_rdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req_valid", bus.mem_req_valid, 0);
    check("rst_rsp_valid", bus.fm2cache_rd_rsp.valid, 0);
    check("rst_rsp_tq", bus.fm2cache_rd_rsp.tq_id, 0);
    check("rst_rsp_data", bus.fm2cache_rd_rsp.data, 0);
    check("rst_fm_ready", bus.fm_ready, 1);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_err_unexp", err_unexp_rsp, 0);
    rst = 1'b1;
    tick();

    // Single fill with a 3-cycle memory read latency.
    bus.mem_req_ready = 1'b1;
    push(FILL_REQ, 26'h0000123, 2'd2, '0);
    check("fill_req_valid", bus.mem_req_valid, 1);
    check("fill_req_we", bus.mem_req_we, 0);
    check("fill_req_addr", bus.mem_req_addr, 26'h0000123);
    tick();
    check("fill_issued_idle", bus.mem_req_valid, 0);
    tick();
    tick();
    check("fill_no_early_rsp", bus.fm2cache_rd_rsp.valid, 0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = PAT_A5;
    tick();
    bus.mem_rsp_valid = 1'b0;
    check("fill_rsp_valid", bus.fm2cache_rd_rsp.valid, 1);
    check("fill_rsp_tq", bus.fm2cache_rd_rsp.tq_id, 2);
    check("fill_rsp_data", bus.fm2cache_rd_rsp.data, PAT_A5);
    tick();
    check("fill_rsp_drop", bus.fm2cache_rd_rsp.valid, 0);

    // Evict then fill to the same line; the small memory model keeps the written line.
    bus.mem_req_ready = 1'b0;
    push(DIRTY_EVICT_OP, 26'h10, 2'd0, DATA_D);
    push(FILL_REQ, 26'h10, 2'd1, '0);
    check("ord_first_we", bus.mem_req_we, 1);
    check("ord_first_addr", bus.mem_req_addr, 26'h10);
    check("ord_first_wdata", bus.mem_req_wdata, DATA_D);
    mem_line = bus.mem_req_wdata;
    bus.mem_req_ready = 1'b1;
    tick();
    check("ord_second_valid", bus.mem_req_valid, 1);
    check("ord_second_we", bus.mem_req_we, 0);
    check("ord_second_addr", bus.mem_req_addr, 26'h10);
    tick();
    bus.mem_req_ready = 1'b0;
    check("ord_drained", bus.mem_req_valid, 0);
    check("ord_no_evict_rsp", bus.fm2cache_rd_rsp.valid, 0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = mem_line;
    tick();
    bus.mem_rsp_valid = 1'b0;
    check("ord_rsp_valid", bus.fm2cache_rd_rsp.valid, 1);
    check("ord_rsp_tq", bus.fm2cache_rd_rsp.tq_id, 1);
    check("ord_rsp_data", bus.fm2cache_rd_rsp.data, DATA_D);

    // Backpressure: memory stalled while the FIFO fills and overflows.
    pulse_reset();
    tick();
    for (int i = 0; i < 5; i++)
      push(DIRTY_EVICT_OP, 26'(32'h20 + i), 2'd0, 128'(i));
    check("bp_ready_after5", bus.fm_ready, 1);
    push(DIRTY_EVICT_OP, 26'h25, 2'd0, 128'd5);
    check("bp_ready_after6", bus.fm_ready, 0);
    push(DIRTY_EVICT_OP, 26'h26, 2'd0, 128'd6);
    push(DIRTY_EVICT_OP, 26'h27, 2'd0, 128'd7);
    check("bp_no_ovf_at8", err_overflow, 0);
    push(DIRTY_EVICT_OP, 26'h28, 2'd0, 128'd8);
    check("bp_ovf_at9", err_overflow, 1);
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_drain%0d_valid", i), bus.mem_req_valid, 1);
      check($sformatf("bp_drain%0d_addr", i), bus.mem_req_addr, 26'(32'h20 + i));
      check($sformatf("bp_drain%0d_data", i), bus.mem_req_wdata, 128'(i));
      tick();
    end
    check("bp_empty", bus.mem_req_valid, 0);
    check("bp_ready_back", bus.fm_ready, 1);
    bus.mem_req_ready = 1'b0;

    // Full FIFO with push and pop in the same cycle.
    pulse_reset();
    tick();
    for (int i = 0; i < 8; i++)
      push(DIRTY_EVICT_OP, 26'(32'h40 + i), 2'd0, '0);
    check("full_ready_low", bus.fm_ready, 0);
    bus.cache2fm_req_q3.valid   = 1'b1;
    bus.cache2fm_req_q3.reqtype = DIRTY_EVICT_OP;
    bus.cache2fm_req_q3.address = 26'h48;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.cache2fm_req_q3.valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    check("full_pp_no_ovf", err_overflow, 0);
    check("full_pp_head", bus.mem_req_addr, 26'h41);
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_drain%0d_addr", i), bus.mem_req_addr, 26'(32'h41 + i));
      tick();
    end
    check("full_count8_empty", bus.mem_req_valid, 0);
    bus.mem_req_ready = 1'b0;

    // Outstanding-fill limit: six fills, only four tags.
    pulse_reset();
    tick();
    for (int i = 0; i < 6; i++)
      push(FILL_REQ, 26'(32'h60 + i), 2'(i), '0);
    bus.mem_req_ready = 1'b1;
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_req_valid) issued++;
      tick();
    end
    check("lim_issued", 128'(issued), 4);
    check("lim_stalled", bus.mem_req_valid, 0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 128'h100;
    tick();
    bus.mem_rsp_valid = 1'b0;
    check("lim_rsp0_tq", bus.fm2cache_rd_rsp.tq_id, 0);
    check("lim_release", bus.mem_req_valid, 1);
    check("lim_release_addr", bus.mem_req_addr, 26'h64);
    tick();
    check("lim_restall", bus.mem_req_valid, 0);
    for (int i = 1; i < 6; i++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 128'(32'h100 + i);
      tick();
      exp_tq = 2'(i);
      check($sformatf("lim_rsp%0d_tq", i), bus.fm2cache_rd_rsp.tq_id, exp_tq);
      check($sformatf("lim_rsp%0d_data", i), bus.fm2cache_rd_rsp.data, 128'(32'h100 + i));
    end
    bus.mem_rsp_valid = 1'b0;
    tick();
    check("lim_rsp_done", bus.fm2cache_rd_rsp.valid, 0);
    check("lim_no_unexp", err_unexp_rsp, 0);

    // Reset while two fills are outstanding.
    pulse_reset();
    tick();
    bus.mem_req_ready = 1'b1;
    push(FILL_REQ, 26'h70, 2'd1, '0);
    push(FILL_REQ, 26'h71, 2'd2, '0);
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b0;
    #2;
    check("mid_rst_req_valid", bus.mem_req_valid, 0);
    check("mid_rst_rsp_valid", bus.fm2cache_rd_rsp.valid, 0);
    check("mid_rst_fm_ready", bus.fm_ready, 1);
    check("mid_rst_err_unexp", err_unexp_rsp, 0);
    rst = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = PAT_A5;
    tick();
    bus.mem_rsp_valid = 1'b0;
    check("mid_unexp_set", err_unexp_rsp, 1);
    check("mid_no_rsp", bus.fm2cache_rd_rsp.valid, 0);
    tick();
    check("mid_no_rsp_later", bus.fm2cache_rd_rsp.valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
